// File: rtl/enqueue_arbiter.sv
// Round-robin arbiter for two level-request producers feeding a shared byte queue.
// Request sampled in IDLE -> one-cycle enqueue/ack next cycle; grants withheld while len_in >= DEPTH.
module enqueue_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_in,
  input  logic [WIDTH-1:0] data0_in,
  output logic             ack0_out,
  input  logic             req1_in,
  input  logic [WIDTH-1:0] data1_in,
  output logic             ack1_out,
  input  logic [3:0]       len_in,
  output logic             enqueue_out,
  output logic [WIDTH-1:0] data_out,
  output logic             grant_id_out,
  output logic             full_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             prio_nxt;
  logic             win;
  logic             winner_req;
  logic [WIDTH-1:0] data_nxt;
  logic             gid_nxt;

  // Occupancy above DEPTH is treated the same as exactly full.
  assign full_out = (len_in >= 4'(DEPTH));

  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    data_nxt   = data_out;
    gid_nxt    = grant_id_out;
    win        = 1'b0;
    winner_req = grant_id_out ? req1_in : req0_in;

    if (req0_in && req1_in) begin
      win = prio;
    end else begin
      win = req1_in;
    end

    case (state)
      IDLE: begin
        if (!full_out && (req0_in || req1_in)) begin
          state_nxt = GRANT;
          prio_nxt  = ~win;
          data_nxt  = win ? data1_in : data0_in;
          gid_nxt   = win;
        end
      end
      GRANT: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Only the last winner's request matters here; the other producer waits.
        if (!winner_req) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    enqueue_out = 1'b0;
    ack0_out    = 1'b0;
    ack1_out    = 1'b0;
    if (state == GRANT) begin
      enqueue_out = 1'b1;
      ack0_out    = ~grant_id_out;
      ack1_out    = grant_id_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= 1'b0;
      data_out     <= '0;
      grant_id_out <= 1'b0;
    end else begin
      state        <= state_nxt;
      prio         <= prio_nxt;
      data_out     <= data_nxt;
      grant_id_out <= gid_nxt;
    end
  end

endmodule

// File: tb/tb_enqueue_arbiter.sv
// Self-checking bench for enqueue_arbiter: directed vector table, corner sequences, randomized producers.
module tb_enqueue_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_in, req1_in;
  logic [7:0] data0_in, data1_in;
  logic       ack0_out, ack1_out;
  logic [3:0] len_in;
  logic       enqueue_out;
  logic [7:0] data_out;
  logic       grant_id_out;
  logic       full_out;

  always #5 clock = ~clock;

  enqueue_arbiter #(.DEPTH(8), .WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req0_in(req0_in), .data0_in(data0_in), .ack0_out(ack0_out),
    .req1_in(req1_in), .data1_in(data1_in), .ack1_out(ack1_out),
    .len_in(len_in), .enqueue_out(enqueue_out), .data_out(data_out),
    .grant_id_out(grant_id_out), .full_out(full_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a grant is either happening now, or the arbiter is waiting for the
  // winner to let go, or it is free to pick; prio names who wins a tie.
  bit         m_prio, m_gnt, m_hold, m_win, m_gid;
  logic [7:0] m_data;

  task automatic model_update();
    if (reset) begin
      m_prio = 0; m_gnt = 0; m_hold = 0; m_win = 0; m_gid = 0; m_data = 8'h00;
    end else if (m_gnt) begin
      m_gnt = 0; m_hold = 1;
    end else if (m_hold) begin
      if (!(m_win ? req1_in : req0_in)) m_hold = 0;
    end else if (int'(len_in) < 8 && (req0_in || req1_in)) begin
      m_win  = (req0_in && req1_in) ? m_prio : (req0_in ? 1'b0 : 1'b1);
      m_gnt  = 1;
      m_data = m_win ? data1_in : data0_in;
      m_gid  = m_win;
      m_prio = !m_win;
    end
  endtask

  logic       obs_enq, obs_ack0, obs_ack1, obs_gid, obs_full;
  logic [7:0] obs_data;
  int         cyc = 0;
  int         last_enq = -1;
  int         n_enq = 0;
  bit         gq[$];

  task automatic step(input bit use_model);
    #1;
    obs_enq = enqueue_out; obs_ack0 = ack0_out; obs_ack1 = ack1_out;
    obs_data = data_out; obs_gid = grant_id_out; obs_full = full_out;
    if (use_model) begin
      chk("mdl_enq",  enqueue_out,  m_gnt);
      chk("mdl_ack0", ack0_out,     m_gnt && !m_win);
      chk("mdl_ack1", ack1_out,     m_gnt && m_win);
      chk("mdl_data", data_out,     m_data);
      chk("mdl_gid",  grant_id_out, m_gid);
      chk("mdl_full", full_out,     int'(len_in) >= 8);
    end
    if (enqueue_out === 1'b1) begin
      if (last_enq >= 0) chk("enq_spacing", (cyc - last_enq) >= 3, 1);
      last_enq = cyc;
      n_enq++;
      gq.push_back(grant_id_out);
    end
    @(posedge clock);
    model_update();
    cyc++;
    if (reset) last_enq = -1;
    @(negedge clock);
  endtask

  // Queue occupancy environment: len_in follows enqueues and optional dequeues one cycle later.
  int q_len = 0;
  bit deq = 0;

  task automatic qstep(input bit use_model);
    int d;
    d = (deq && q_len > 0) ? 1 : 0;
    len_in = q_len[3:0];
    step(use_model);
    q_len = q_len + (obs_enq === 1'b1 ? 1 : 0) - d;
  endtask

  bit a_acked[2];
  int a_hold[2];
  int a_gap[2];

  task automatic agents(input int max_hold, input int max_gap);
    logic r;
    for (int p = 0; p < 2; p++) begin
      r = (p == 1) ? req1_in : req0_in;
      if (r) begin
        if (a_acked[p]) begin
          if (a_hold[p] > 0) a_hold[p]--;
          else begin
            r = 1'b0;
            a_gap[p] = int'($urandom_range(max_gap, 0));
          end
        end
      end else if (a_gap[p] > 0) begin
        a_gap[p]--;
      end else begin
        r = 1'b1;
        a_acked[p] = 0;
        a_hold[p] = int'($urandom_range(max_hold, 0));
        if (p == 1) data1_in = 8'($urandom); else data0_in = 8'($urandom);
      end
      if (p == 1) req1_in = r; else req0_in = r;
    end
  endtask

  task automatic run_agents(input int n, input int max_hold, input int max_gap, input int deq_pct);
    for (int i = 0; i < n; i++) begin
      agents(max_hold, max_gap);
      deq = (int'($urandom_range(99, 0)) < deq_pct);
      qstep(1);
      if (obs_ack0 === 1'b1) a_acked[0] = 1;
      if (obs_ack1 === 1'b1) a_acked[1] = 1;
    end
    deq = 0;
  endtask

  task automatic do_reset();
    reset = 1; req0_in = 0; req1_in = 0; data0_in = 0; data1_in = 0;
    q_len = 0; deq = 0;
    qstep(1); qstep(1);
    reset = 0;
    q_len = 0;
    for (int p = 0; p < 2; p++) begin
      a_acked[p] = 0; a_hold[p] = 0; a_gap[p] = 0;
    end
  endtask

  typedef struct {
    logic       rst, r0, r1;
    logic [7:0] d0, d1;
    logic [3:0] len;
    logic       enq, a0, a1;
    logic [7:0] dat;
    logic       gid, full;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  got;
    int  k;
    bit  seen;
    logic [7:0] dseen;
    int  snap;

    //          rst r0 r1 d0     d1     len    enq a0 a1 dat    gid full
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd0,  0, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h99, 8'h00, 4'd0,  0, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h99, 8'h00, 4'd0,  1, 1, 0, 8'h99, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h99, 8'h00, 4'd1,  0, 0, 0, 8'h99, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd1,  0, 0, 0, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 1, 8'hA5, 8'h3C, 4'd1,  0, 0, 0, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 1, 8'hA5, 8'h3C, 4'd1,  1, 0, 1, 8'h3C, 1, 0});
    tbl.push_back('{0, 1, 0, 8'hA5, 8'h3C, 4'd2,  0, 0, 0, 8'h3C, 1, 0});
    tbl.push_back('{0, 1, 0, 8'hA5, 8'h00, 4'd2,  0, 0, 0, 8'h3C, 1, 0});
    tbl.push_back('{0, 1, 0, 8'hA5, 8'h00, 4'd2,  1, 1, 0, 8'hA5, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd3,  0, 0, 0, 8'hA5, 0, 0});
    tbl.push_back('{0, 0, 1, 8'h00, 8'h5A, 4'd8,  0, 0, 0, 8'hA5, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h00, 8'h5A, 4'd8,  0, 0, 0, 8'hA5, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h00, 8'h5A, 4'd7,  0, 0, 0, 8'hA5, 0, 0});
    tbl.push_back('{0, 0, 1, 8'h00, 8'h5A, 4'd7,  1, 0, 1, 8'h5A, 1, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd8,  0, 0, 0, 8'h5A, 1, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd9,  0, 0, 0, 8'h5A, 1, 1});
    tbl.push_back('{0, 1, 0, 8'h11, 8'h00, 4'd15, 0, 0, 0, 8'h5A, 1, 1});
    tbl.push_back('{0, 1, 0, 8'h11, 8'h00, 4'd15, 0, 0, 0, 8'h5A, 1, 1});
    tbl.push_back('{0, 1, 0, 8'h11, 8'h00, 4'd0,  0, 0, 0, 8'h5A, 1, 0});
    tbl.push_back('{1, 1, 0, 8'h11, 8'h00, 4'd0,  1, 1, 0, 8'h11, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 4'd0,  0, 0, 0, 8'h00, 0, 0});

    reset = 1; req0_in = 0; req1_in = 0; data0_in = 0; data1_in = 0; len_in = 0;
    step(0);
    step(0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; req0_in = tbl[i].r0; req1_in = tbl[i].r1;
      data0_in = tbl[i].d0; data1_in = tbl[i].d1; len_in = tbl[i].len;
      step(0);
      chk($sformatf("tbl%0d_enq", i),  obs_enq,  tbl[i].enq);
      chk($sformatf("tbl%0d_ack0", i), obs_ack0, tbl[i].a0);
      chk($sformatf("tbl%0d_ack1", i), obs_ack1, tbl[i].a1);
      chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].dat);
      chk($sformatf("tbl%0d_gid", i),  obs_gid,  tbl[i].gid);
      chk($sformatf("tbl%0d_full", i), obs_full, tbl[i].full);
    end

    // Full backpressure, then a single dequeue releases the pending request.
    do_reset();
    q_len = 8; req1_in = 1; data1_in = 8'h5A;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      qstep(1);
      got += int'(obs_ack0) + int'(obs_ack1);
    end
    chk("full_no_ack", got, 0);
    deq = 1; qstep(1); deq = 0;
    seen = 0; k = 0; dseen = 8'h00;
    for (int i = 1; i <= 4 && !seen; i++) begin
      qstep(1);
      if (obs_ack1 === 1'b1) begin seen = 1; k = i; dseen = obs_data; end
    end
    chk("full_resume_ack1", seen, 1);
    chk("full_resume_latency", k, 2);
    chk("full_resume_data", dseen, 8'h5A);
    req1_in = 0; qstep(1); qstep(1);

    // Winner holds its request in RELEASE while the other producer waits.
    do_reset();
    req0_in = 1; req1_in = 1; data0_in = 8'h21; data1_in = 8'h42;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      qstep(1);
      if (obs_ack0 === 1'b1 || obs_ack1 === 1'b1) begin
        seen = 1;
        chk("hold_first_winner0", {obs_ack0, obs_ack1}, 2'b10);
      end
    end
    chk("hold_first_grant_seen", seen, 1);
    snap = n_enq;
    for (int i = 0; i < 10; i++) qstep(1);
    chk("hold_no_enq", n_enq - snap, 0);
    req0_in = 0;
    seen = 0; dseen = 8'h00;
    for (int i = 0; i < 4 && !seen; i++) begin
      qstep(1);
      if (obs_ack1 === 1'b1) begin seen = 1; dseen = obs_data; end
    end
    chk("hold_other_granted", seen, 1);
    chk("hold_other_data", dseen, 8'h42);
    req1_in = 0; qstep(1); qstep(1);

    // Reset on the selection edge: no grant, prio back to producer 0.
    do_reset();
    req0_in = 1; data0_in = 8'h77;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      qstep(1);
      if (obs_ack0 === 1'b1) seen = 1;
    end
    chk("rst_pre_grant", seen, 1);
    req0_in = 0; qstep(1); qstep(1);
    reset = 1; req0_in = 1; req1_in = 1; data0_in = 8'h88; data1_in = 8'h99;
    qstep(1);
    reset = 0;
    qstep(1);
    chk("rst_no_enq", obs_enq, 0);
    chk("rst_no_ack", {obs_ack0, obs_ack1}, 2'b00);
    qstep(1);
    chk("rst_tie_ack0", obs_ack0, 1);
    chk("rst_tie_ack1", obs_ack1, 0);
    chk("rst_tie_data", obs_data, 8'h88);

    // Fill an empty queue with alternating producers.
    do_reset();
    n_enq = 0; gq.delete();
    run_agents(45, 0, 0, 0);
    chk("fill_enq_count", n_enq, 8);
    chk("fill_len", q_len, 8);
    chk("fill_pending", (req0_in && !a_acked[0]) || (req1_in && !a_acked[1]), 1);
    if (gq.size() > 0) chk("fill_first_gid", gq[0], 0);
    for (int i = 1; i < gq.size(); i++) chk($sformatf("fill_alt%0d", i), gq[i], !gq[i-1]);

    // Randomized producers and dequeues against the reference model.
    do_reset();
    q_len = int'($urandom_range(8, 0));
    run_agents(3000, 3, 4, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
